// File: rtl/ucode_sequencer_if.sv
// Bundle between the microcode sequencer and its surroundings: start/control inputs,
// the microcode memory read port, the decoded ucodeop field set and status outputs.
interface ucode_sequencer_if #(parameter int UPC_W = 8);
    logic             start;
    logic [UPC_W-1:0] start_pc;
    logic             stall;
    logic             zero_flag;
    logic             um_rd_en;
    logic [UPC_W-1:0] um_addr;
    logic [31:0]      um_rdata;
    logic             uop_valid;
    logic [3:0]       uop_port_a_reg;
    logic [3:0]       uop_port_b_reg;
    logic             uop_port_a_we;
    logic [3:0]       uop_alu_op;
    logic             uop_alu_use_b_imm;
    logic             uop_alu_shift_dir;
    logic             uop_jump_on_zero;
    logic             uop_ex_jump;
    logic             uop_in_alu;
    logic             uop_in_rf;
    logic             uop_in_dmem;
    logic             uop_in_imm;
    logic             uop_out_rf_write;
    logic             uop_out_dm_write;
    logic [7:0]       uop_imm;
    logic             uop_done;
    logic             busy;
    logic             done;
    logic [UPC_W-1:0] upc;
    logic [1:0]       dbg_state;

    // Handshake: start is a request sampled only while the sequencer is idle (busy=0);
    // a read issued with um_rd_en in one cycle returns um_rdata in the following cycle.
    modport master (
        input  start, start_pc, stall, zero_flag, um_rdata,
        output um_rd_en, um_addr, uop_valid, uop_port_a_reg, uop_port_b_reg,
               uop_port_a_we, uop_alu_op, uop_alu_use_b_imm, uop_alu_shift_dir,
               uop_jump_on_zero, uop_ex_jump, uop_in_alu, uop_in_rf, uop_in_dmem,
               uop_in_imm, uop_out_rf_write, uop_out_dm_write, uop_imm, uop_done,
               busy, done, upc, dbg_state
    );

    modport slave (
        output start, start_pc, stall, zero_flag, um_rdata,
        input  um_rd_en, um_addr, uop_valid, uop_port_a_reg, uop_port_b_reg,
               uop_port_a_we, uop_alu_op, uop_alu_use_b_imm, uop_alu_shift_dir,
               uop_jump_on_zero, uop_ex_jump, uop_in_alu, uop_in_rf, uop_in_dmem,
               uop_in_imm, uop_out_rf_write, uop_out_dm_write, uop_imm, uop_done,
               busy, done, upc, dbg_state
    );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: fetch / wait / execute loop over a synchronous-read microcode ROM,
// decoding the held instruction word onto the ucodeop fields and resolving jumps.
module ucode_sequencer #(
    parameter int UPC_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    ucode_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [UPC_W-1:0] r_upc;
    logic [UPC_W-1:0] w_upc_nxt;
    logic [UPC_W-1:0] w_target;
    logic [31:0]      r_ir;
    logic [31:0]      w_ir_nxt;
    logic [31:0]      w_uop;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_exec;

    // Immediate is zero-extended or truncated to the counter width.
    assign w_target = UPC_W'(r_ir[30:23]);
    assign w_exec   = (r_state == S_EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_upc   <= '0;
            r_ir    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_ir    <= w_ir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_ir_nxt    = r_ir;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_upc_nxt   = bus.start_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                w_ir_nxt    = bus.um_rdata;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // SignalDone outranks both jump kinds; ExJump outranks JumpOnZero.
                if (!bus.stall) begin
                    if (r_ir[31]) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                        if (r_ir[16]) begin
                            w_upc_nxt = w_target;
                        end else if (r_ir[15] && bus.zero_flag) begin
                            w_upc_nxt = w_target;
                        end else begin
                            w_upc_nxt = r_upc + UPC_W'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fields read as NOP outside EXEC so no write enable can leak out.
    assign w_uop = w_exec ? r_ir : 32'd0;

    assign bus.um_rd_en          = (r_state == S_FETCH);
    assign bus.um_addr           = r_upc;
    assign bus.uop_valid         = w_exec;
    assign bus.uop_port_a_reg    = w_uop[3:0];
    assign bus.uop_port_b_reg    = w_uop[7:4];
    assign bus.uop_port_a_we     = w_uop[8];
    assign bus.uop_alu_op        = w_uop[12:9];
    assign bus.uop_alu_use_b_imm = w_uop[13];
    assign bus.uop_alu_shift_dir = w_uop[14];
    assign bus.uop_jump_on_zero  = w_uop[15];
    assign bus.uop_ex_jump       = w_uop[16];
    assign bus.uop_in_alu        = w_uop[17];
    assign bus.uop_in_rf         = w_uop[18];
    assign bus.uop_in_dmem       = w_uop[19];
    assign bus.uop_in_imm        = w_uop[20];
    assign bus.uop_out_rf_write  = w_uop[21];
    assign bus.uop_out_dm_write  = w_uop[22];
    assign bus.uop_imm           = w_uop[30:23];
    assign bus.uop_done          = w_uop[31];
    assign bus.busy              = (r_state != S_IDLE);
    assign bus.done              = r_done;
    assign bus.upc               = r_upc;
    assign bus.dbg_state         = r_state;
endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: behavioural ROM, per-feature scenario tasks and a
// fetch-address scoreboard queue.
module tb_ucode_sequencer;
    localparam int UPC_W = 8;
    localparam logic [31:0] W_DONE = 32'h8000_0000;
    localparam logic [31:0] W_PLAIN = 32'h0000_0231;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_run = 0;
    int n_fail = 0;
    logic [31:0] rom [256];
    logic [UPC_W-1:0] exp_q [$];
    logic [31:0] uop_vec;
    logic [UPC_W+UPC_W+35:0] all_out;

    ucode_sequencer_if #(.UPC_W(UPC_W)) bus ();

    ucode_sequencer #(.UPC_W(UPC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read microcode ROM
    always @(posedge clk) begin
        if (bus.um_rd_en) bus.um_rdata <= rom[bus.um_addr];
    end

    // Field outputs reassembled in word-map order
    assign uop_vec = {bus.uop_done, bus.uop_imm, bus.uop_out_dm_write, bus.uop_out_rf_write,
                      bus.uop_in_imm, bus.uop_in_dmem, bus.uop_in_rf, bus.uop_in_alu,
                      bus.uop_ex_jump, bus.uop_jump_on_zero, bus.uop_alu_shift_dir,
                      bus.uop_alu_use_b_imm, bus.uop_alu_op, bus.uop_port_a_we,
                      bus.uop_port_b_reg, bus.uop_port_a_reg};
    assign all_out = {uop_vec, bus.um_rd_en, bus.uop_valid, bus.busy, bus.done, bus.upc, bus.um_addr};

    // ---------------- driver / observer tasks ----------------
    task automatic start_routine(input logic [UPC_W-1:0] pc);
        bus.start    = 1'b1;
        bus.start_pc = pc;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_fetch(output logic [UPC_W-1:0] addr, output bit ok);
        ok   = 1'b0;
        addr = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.um_rd_en) begin
                addr = bus.um_addr;
                ok   = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_run++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs got %0h exp 0", all_out); end
        n_run++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", bus.dbg_state); end
        rst_n = 1'b1;
        @(negedge clk);
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %0b exp 0", bus.busy); end
    endtask

    task automatic test_basic();
        logic [UPC_W-1:0] e;
        rom[8'h10] = W_PLAIN;
        rom[8'h11] = W_DONE;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        start_routine(8'h10);
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bus.um_rd_en !== 1'b1 || bus.um_addr !== e) begin n_fail++; $display("FAIL basic_fetch0 got en=%0b addr=%0h exp en=1 addr=%0h", bus.um_rd_en, bus.um_addr, e); end
        n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b exp 1", bus.busy); end
        @(negedge clk);
        n_run++; if (bus.uop_valid !== 1'b0 || bus.um_rd_en !== 1'b0 || uop_vec !== '0) begin n_fail++; $display("FAIL basic_wait_nop got valid=%0b en=%0b vec=%0h exp 0/0/0", bus.uop_valid, bus.um_rd_en, uop_vec); end
        @(negedge clk);
        n_run++; if (bus.uop_valid !== 1'b1) begin n_fail++; $display("FAIL basic_exec_valid got %0b exp 1", bus.uop_valid); end
        n_run++; if ({bus.uop_port_a_reg, bus.uop_port_b_reg, bus.uop_port_a_we, bus.uop_alu_op} !== {4'd1, 4'd3, 1'b0, 4'd1})
            begin n_fail++; $display("FAIL basic_fields got a=%0d b=%0d we=%0b op=%0d exp a=1 b=3 we=0 op=1", bus.uop_port_a_reg, bus.uop_port_b_reg, bus.uop_port_a_we, bus.uop_alu_op); end
        n_run++; if (uop_vec !== W_PLAIN) begin n_fail++; $display("FAIL basic_vec got %0h exp %0h", uop_vec, W_PLAIN); end
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bus.um_rd_en !== 1'b1 || bus.um_addr !== e || bus.uop_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fetch1 got en=%0b addr=%0h valid=%0b exp 1/%0h/0", bus.um_rd_en, bus.um_addr, bus.uop_valid, e); end
        repeat (2) @(negedge clk);
        n_run++; if (bus.uop_done !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_done_exec got udone=%0b done=%0b busy=%0b exp 1/0/1", bus.uop_done, bus.done, bus.busy); end
        @(negedge clk);
        n_run++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.upc !== 8'h11) begin n_fail++; $display("FAIL basic_done_pulse got done=%0b busy=%0b upc=%0h exp 1/0/11", bus.done, bus.busy, bus.upc); end
        @(negedge clk);
        n_run++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %0b exp 0", bus.done); end
    endtask

    task automatic test_ex_jump();
        logic [UPC_W-1:0] a, e;
        bit ok;
        for (int v = 0; v < 2; v++) begin
            rom[8'h20] = 32'h2001_0000 | (v == 1 ? 32'h0000_8000 : 32'h0);
            rom[8'h40] = W_DONE;
            bus.zero_flag = 1'b0;
            exp_q.push_back(8'h20);
            exp_q.push_back(8'h40);
            start_routine(8'h20);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_fetch(a, ok);
                n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL ex_jump_v%0d_fetch got ok=%0b addr=%0h exp %0h", v, ok, a, e); end
            end
            wait_done(ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL ex_jump_v%0d_done got none exp pulse", v); end
        end
    endtask

    task automatic test_jump_on_zero();
        logic [UPC_W-1:0] a, e;
        bit ok;
        rom[8'h20] = 32'h0280_8000;
        rom[8'h05] = W_DONE;
        rom[8'h21] = W_DONE;
        for (int zf = 1; zf >= 0; zf--) begin
            bus.zero_flag = zf[0];
            exp_q.push_back(8'h20);
            exp_q.push_back(zf == 1 ? 8'h05 : 8'h21);
            start_routine(8'h20);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                wait_fetch(a, ok);
                n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL joz_zf%0d_fetch got ok=%0b addr=%0h exp %0h", zf, ok, a, e); end
            end
            wait_done(ok);
            n_run++; if (!ok) begin n_fail++; $display("FAIL joz_zf%0d_done got none exp pulse", zf); end
        end
        bus.zero_flag = 1'b0;
    endtask

    task automatic test_stall();
        logic [UPC_W-1:0] a, e;
        logic [31:0] w;
        bit ok;
        bit held;
        w = 32'h2866_AB6A;
        rom[8'h30] = w;
        rom[8'h31] = W_DONE;
        rom[8'h50] = W_DONE;
        bus.zero_flag = 1'b0;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        start_routine(8'h30);
        e = exp_q.pop_front();
        wait_fetch(a, ok);
        n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL stall_fetch0 got ok=%0b addr=%0h exp %0h", ok, a, e); end
        repeat (2) @(negedge clk);
        n_run++; if (bus.uop_valid !== 1'b1 || uop_vec !== w) begin n_fail++; $display("FAIL stall_exec got valid=%0b vec=%0h exp 1/%0h", bus.uop_valid, uop_vec, w); end
        bus.stall = 1'b1;
        held = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.zero_flag = (k != 4) ? k[0] : 1'b0;
            @(negedge clk);
            if (bus.uop_valid !== 1'b1 || uop_vec !== w || bus.um_rd_en !== 1'b0) held = 1'b0;
        end
        n_run++; if (!held) begin n_fail++; $display("FAIL stall_hold got changed outputs exp held valid=1 vec=%0h", w); end
        bus.stall = 1'b0;
        e = exp_q.pop_front();
        wait_fetch(a, ok);
        n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL stall_next_fetch got ok=%0b addr=%0h exp %0h", ok, a, e); end
        wait_done(ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL stall_done got none exp pulse"); end
    endtask

    task automatic test_wrap_and_busy_start();
        logic [UPC_W-1:0] a, e;
        bit ok;
        rom[8'hFF] = W_PLAIN;
        rom[8'h00] = W_DONE;
        rom[8'h80] = W_DONE;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        start_routine(8'hFF);
        e = exp_q.pop_front();
        wait_fetch(a, ok);
        n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL wrap_fetch0 got ok=%0b addr=%0h exp %0h", ok, a, e); end
        bus.start    = 1'b1;
        bus.start_pc = 8'h80;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        e = exp_q.pop_front();
        wait_fetch(a, ok);
        n_run++; if (!ok || a !== e) begin n_fail++; $display("FAIL wrap_fetch1 got ok=%0b addr=%0h exp %0h", ok, a, e); end
        wait_done(ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL wrap_done got none exp pulse"); end
    endtask

    task automatic test_back_to_back();
        logic [UPC_W-1:0] e;
        bit ok;
        rom[8'h60] = W_DONE;
        rom[8'h61] = W_DONE;
        start_routine(8'h60);
        wait_done(ok);
        n_run++; if (!ok || bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_first_done got ok=%0b busy=%0b exp 1/0", ok, bus.busy); end
        exp_q.push_back(8'h61);
        start_routine(8'h61);
        @(negedge clk);
        e = exp_q.pop_front();
        n_run++; if (bus.um_rd_en !== 1'b1 || bus.um_addr !== e) begin n_fail++; $display("FAIL b2b_fetch got en=%0b addr=%0h exp 1/%0h", bus.um_rd_en, bus.um_addr, e); end
        wait_done(ok);
        n_run++; if (!ok) begin n_fail++; $display("FAIL b2b_second_done got none exp pulse"); end
    endtask

    task automatic test_reset_mid_routine();
        logic [UPC_W-1:0] a;
        bit ok;
        bit quiet;
        rom[8'h70] = W_PLAIN;
        start_routine(8'h70);
        wait_fetch(a, ok);
        n_run++; if (!ok || a !== 8'h70) begin n_fail++; $display("FAIL rst_mid_fetch got ok=%0b addr=%0h exp 70", ok, a); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_run++; if (all_out !== '0 || bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_outputs got %0h st=%0d exp 0/0", all_out, bus.dbg_state); end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.um_rd_en !== 1'b0) quiet = 1'b0;
        end
        n_run++; if (!quiet) begin n_fail++; $display("FAIL rst_mid_idle got activity after reset exp idle with no done"); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.start_pc  = '0;
        bus.stall     = 1'b0;
        bus.zero_flag = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        test_reset();
        test_basic();
        test_ex_jump();
        test_jump_on_zero();
        test_stall();
        test_wrap_and_busy_start();
        test_back_to_back();
        test_reset_mid_routine();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
